int_seq: RTL and testbench
==========================

Name: int_seq

Overview:
Interrupt entry/exit sequencer for the pipelined processor. It detects an external interrupt, freezes fetch and drains the pipeline. It then drives the registered interrupt flag (sf1) that forces the ALU control unit into SP pass-through so PC is pushed, and reads the vector so PC can be loaded. It holds a shadow copy of the condition flags and restores it when RTI retires.

Parameters:
PIPE_DEPTH, 4, drain cycles required before the push micro-op (1..7)
VEC_ADDR, 8'h01, data-memory address holding the interrupt vector
ADDR_W, 8, width of vec_addr

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
intr  in  1  external interrupt request, level, synchronous to clk
stall_in  in  1  hazard stall active in pipeline
branch_pending  in  1  control transfer in flight in EX/MEM
rti_retire  in  1  RTI instruction retiring in WB this cycle
flags_in  in  4  current CCR {V,C,N,Z}
sf1  out  1  forces CU into push mode (pass R[ra]=SP, add 1)
freeze_fetch  out  1  hold PC/IF stage
inject_valid  out  1  injected push-PC micro-op valid
mem_rd_vec  out  1  read data memory at vec_addr
vec_addr  out  ADDR_W  constant VEC_ADDR, valid when mem_rd_vec=1
pc_load  out  1  load PC from memory read data
int_ack  out  1  one-cycle acknowledge, coincident with pc_load
flags_saved  out  4  shadow CCR
flags_restore  out  1  one-cycle pulse: CCR <= flags_saved
busy  out  1  sequencer not in IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, intr_q=0, int_pending=0, in_isr=0, cnt=0, flags_saved=0. All outputs are 0 except vec_addr=VEC_ADDR. Reset mid-sequence aborts immediately, with no partial push or load.
- Edge detect: intr_q <= intr each edge. Rising edge (intr & ~intr_q) sets int_pending at that edge. Pending is single-deep: further edges while pending=1 merge. Edges during DRAIN..LOAD or while in_isr=1 stay pending.
- States: IDLE, DRAIN, PUSH, VEC, LOAD. Outputs are Moore, decoded from the registered state.
- IDLE: if int_pending & ~in_isr, go to DRAIN with cnt<=PIPE_DEPTH. Registered in_isr is used.
- DRAIN: freeze_fetch=1.
  - If stall_in | branch_pending, cnt holds.
  - Else if cnt==1, go to PUSH.
  - Else cnt<=cnt-1.
- PUSH (1 cycle): freeze_fetch=1, sf1=1, inject_valid=1. At exit, flags_saved <= flags_in.
- VEC (1 cycle): freeze_fetch=1, mem_rd_vec=1. Memory read latency is 1 cycle.
- LOAD (1 cycle): freeze_fetch=1, pc_load=1, int_ack=1. At exit: int_pending<=0 (unless a new rising edge coincides, in which case it stays 1), in_isr<=1, state<=IDLE.
- busy=1 in every state except IDLE.
- Latency, no stalls: pending set at edge E0. IDLE at E1 goes to DRAIN. DRAIN occupies PIPE_DEPTH cycles, then PUSH, VEC, LOAD. freeze_fetch is high for PIPE_DEPTH+3 consecutive cycles.
- RTI handling:
  - rti_retire=1 with in_isr=1: at that edge in_isr<=0 and flags_restore<=1 for exactly one cycle.
  - rti_retire with in_isr=0 is ignored, with no pulse.
- Nesting: none. A pending request is serviced no earlier than 1 cycle after in_isr clears.
- Simultaneous rti_retire and a new intr edge: RTI completes first. The new interrupt enters DRAIN the cycle after flags_restore.
- stall_in/branch_pending outside DRAIN have no effect.

Test Plan:
1. Reset with rst=0 mid-DRAIN -> state IDLE immediately (async); all outputs 0, vec_addr=8'h01; pending cleared.
2. intr 0->1, no stalls, PIPE_DEPTH=4 -> freeze_fetch high 7 cycles. sf1/inject_valid high in cycle 5 of freeze, mem_rd_vec in cycle 6, pc_load=int_ack in cycle 7. flags_in=4'b1010 at PUSH gives flags_saved=4'b1010.
3. Same as 2 with stall_in=1 for 3 cycles inside DRAIN -> freeze lasts 10 cycles; sf1 is delayed by exactly 3 cycles.
4. Second intr edge during DRAIN, then rti_retire 20 cycles after int_ack -> exactly one flags_restore pulse (4'b1010). The second interrupt enters DRAIN the cycle after; no third sequence occurs.
5. intr held high continuously (no new edge) -> exactly one sequence.
6. rti_retire with in_isr=0 -> no flags_restore, state stays IDLE.

Source files
------------

// File: rtl/int_seq.sv
// rtl/int_seq.sv - interrupt entry/exit sequencer: drain, push PC, fetch vector, load PC, CCR shadow.
module int_seq #(
  parameter int                PIPE_DEPTH = 4,
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] VEC_ADDR   = 8'h01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              intr,
  input  logic              stall_in,
  input  logic              branch_pending,
  input  logic              rti_retire,
  input  logic [3:0]        flags_in,
  output logic              sf1,
  output logic              freeze_fetch,
  output logic              inject_valid,
  output logic              mem_rd_vec,
  output logic [ADDR_W-1:0] vec_addr,
  output logic              pc_load,
  output logic              int_ack,
  output logic [3:0]        flags_saved,
  output logic              flags_restore,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_PUSH  = 3'd2,
    S_VEC   = 3'd3,
    S_LOAD  = 3'd4
  } state_t;

  localparam logic [2:0] DRAIN_INIT = 3'(PIPE_DEPTH);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       intr_q, intr_d;
  logic       int_pending_q, int_pending_d;
  logic       rearm_q, rearm_d;
  logic       in_isr_q, in_isr_d;
  logic [3:0] flags_saved_q, flags_saved_d;
  logic       flags_restore_q, flags_restore_d;
  logic       rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= 3'd0;
      intr_q          <= 1'b0;
      int_pending_q   <= 1'b0;
      rearm_q         <= 1'b0;
      in_isr_q        <= 1'b0;
      flags_saved_q   <= 4'd0;
      flags_restore_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      intr_q          <= intr_d;
      int_pending_q   <= int_pending_d;
      rearm_q         <= rearm_d;
      in_isr_q        <= in_isr_d;
      flags_saved_q   <= flags_saved_d;
      flags_restore_q <= flags_restore_d;
    end
  end

  always_comb begin
    rise            = intr & ~intr_q;
    state_d         = state_q;
    cnt_d           = cnt_q;
    intr_d          = intr;
    int_pending_d   = int_pending_q | rise;
    rearm_d         = rearm_q;
    in_isr_d        = in_isr_q;
    flags_saved_d   = flags_saved_q;
    flags_restore_d = 1'b0;

    sf1          = 1'b0;
    freeze_fetch = 1'b0;
    inject_valid = 1'b0;
    mem_rd_vec   = 1'b0;
    pc_load      = 1'b0;
    int_ack      = 1'b0;
    busy         = (state_q != S_IDLE);

    if (rti_retire && in_isr_q) begin
      in_isr_d        = 1'b0;
      flags_restore_d = 1'b1;
    end

    // An edge arriving while a request is in service is remembered so it survives the LOAD clear.
    if (rise && (state_q == S_DRAIN || state_q == S_PUSH || state_q == S_VEC)) begin
      rearm_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (int_pending_q && !in_isr_q) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_INIT;
        end
      end
      S_DRAIN: begin
        freeze_fetch = 1'b1;
        if (!(stall_in || branch_pending)) begin
          if (cnt_q == 3'd1) state_d = S_PUSH;
          else               cnt_d   = cnt_q - 3'd1;
        end
      end
      S_PUSH: begin
        freeze_fetch  = 1'b1;
        sf1           = 1'b1;
        inject_valid  = 1'b1;
        flags_saved_d = flags_in;
        state_d       = S_VEC;
      end
      S_VEC: begin
        freeze_fetch = 1'b1;
        mem_rd_vec   = 1'b1;
        state_d      = S_LOAD;
      end
      S_LOAD: begin
        freeze_fetch  = 1'b1;
        pc_load       = 1'b1;
        int_ack       = 1'b1;
        int_pending_d = rise | rearm_q;
        rearm_d       = 1'b0;
        in_isr_d      = 1'b1;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign vec_addr      = VEC_ADDR;
  assign flags_saved   = flags_saved_q;
  assign flags_restore = flags_restore_q;

endmodule

// File: tb/tb_int_seq.sv
// tb/tb_int_seq.sv - directed and randomized bench for int_seq against a behavioural model.
module tb_int_seq;
  localparam int         PD = 4;
  localparam logic [7:0] VA = 8'h01;

  logic       clk = 1'b0;
  logic       rst;
  logic       intr, stall_in, branch_pending, rti_retire;
  logic [3:0] flags_in;
  logic       sf1, freeze_fetch, inject_valid, mem_rd_vec, pc_load, int_ack;
  logic       flags_restore, busy;
  logic [7:0] vec_addr;
  logic [3:0] flags_saved;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 drain, 2 push, 3 vector read, 4 load.
  int         m_phase, m_done;
  bit         m_pend, m_isr, m_restore, m_rearm, m_prev;
  logic [3:0] m_saved;

  int_seq #(.PIPE_DEPTH(PD), .ADDR_W(8), .VEC_ADDR(VA)) dut (
    .clk(clk), .rst(rst), .intr(intr), .stall_in(stall_in),
    .branch_pending(branch_pending), .rti_retire(rti_retire), .flags_in(flags_in),
    .sf1(sf1), .freeze_fetch(freeze_fetch), .inject_valid(inject_valid),
    .mem_rd_vec(mem_rd_vec), .vec_addr(vec_addr), .pc_load(pc_load),
    .int_ack(int_ack), .flags_saved(flags_saved), .flags_restore(flags_restore),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_done = 0; m_pend = 0; m_isr = 0;
    m_restore = 0; m_rearm = 0; m_prev = 0; m_saved = 4'd0;
  endtask

  task automatic model_edge();
    bit rise, isr0;
    int ph;
    rise = intr && !m_prev;
    isr0 = m_isr;
    ph   = m_phase;
    m_restore = rti_retire && isr0;
    if (m_restore) m_isr = 0;
    case (ph)
      0: begin
        if (m_pend && !isr0) begin m_phase = 1; m_done = 0; end
        m_pend = m_pend || rise;
      end
      1: begin
        if (rise) m_rearm = 1;
        if (!(stall_in || branch_pending)) begin
          m_done++;
          if (m_done == PD) m_phase = 2;
        end
      end
      2: begin if (rise) m_rearm = 1; m_saved = flags_in; m_phase = 3; end
      3: begin if (rise) m_rearm = 1; m_phase = 4; end
      default: begin
        m_pend = rise || m_rearm; m_rearm = 0; m_isr = 1; m_phase = 0;
      end
    endcase
    m_prev = intr;
  endtask

  task automatic check_outputs(input string tag);
    logic [19:0] obs, exp;
    obs = {sf1, freeze_fetch, inject_valid, mem_rd_vec, pc_load, int_ack, busy,
           flags_restore, flags_saved, vec_addr};
    exp = {m_phase == 2, m_phase != 0, m_phase == 2, m_phase == 3, m_phase == 4,
           m_phase == 4, m_phase != 0, m_restore, m_saved, VA};
    chk(tag, 32'(obs), 32'(exp));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs("cycle_outs");
  endtask

  task automatic run_seq(input int st_lo, input int st_hi,
                         output int flen, output int sf, output int vc, output int ld,
                         output int acks);
    int fcnt;
    fcnt = 0; sf = 0; vc = 0; ld = 0; acks = 0;
    intr = 1'b1;
    for (int c = 0; c < 60; c++) begin
      step();
      if (freeze_fetch) begin
        fcnt++;
        if (sf1)        sf = fcnt;
        if (mem_rd_vec) vc = fcnt;
        if (pc_load)    ld = fcnt;
      end
      if (int_ack) acks++;
      stall_in = freeze_fetch && fcnt >= st_lo && fcnt <= st_hi;
      if (fcnt > 0 && !freeze_fetch) break;
    end
    stall_in = 1'b0;
    flen = fcnt;
  endtask

  initial begin
    int flen, sf, vc, ld, acks, restores;
    bit found;
    rst = 1'b0; intr = 1'b0; stall_in = 1'b0; branch_pending = 1'b0;
    rti_retire = 1'b0; flags_in = 4'b1010;
    model_reset();
    #1;
    check_outputs("reset_outs");
    chk("reset_vec_addr", 32'(vec_addr), 32'h01);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Async reset in the middle of DRAIN
    intr = 1'b1;
    step(); step(); step();
    chk("t1_in_drain", 32'(freeze_fetch), 32'd1);
    #2 rst = 1'b0; intr = 1'b0;
    #1;
    model_reset();
    check_outputs("t1_async_outs");
    chk("t1_busy_async", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    found = 0;
    for (int c = 0; c < 6; c++) begin step(); if (busy) found = 1; end
    chk("t1_pending_cleared", 32'(found), 32'd0);

    // Clean entry, no stalls
    flags_in = 4'b1010;
    run_seq(99, 0, flen, sf, vc, ld, acks);
    chk("t2_freeze_len", flen, 7);
    chk("t2_sf1_cycle", sf, 5);
    chk("t2_vec_cycle", vc, 6);
    chk("t2_load_cycle", ld, 7);
    chk("t2_acks", acks, 1);
    chk("t2_flags_saved", 32'(flags_saved), 32'b1010);
    intr = 1'b0; rti_retire = 1'b1; step();
    chk("t2_restore", 32'(flags_restore), 32'd1);
    rti_retire = 1'b0; step();
    chk("t2_restore_one_cycle", 32'(flags_restore), 32'd0);

    // Three stalled DRAIN cycles
    run_seq(2, 4, flen, sf, vc, ld, acks);
    chk("t3_freeze_len", flen, 10);
    chk("t3_sf1_cycle", sf, 8);
    chk("t3_load_cycle", ld, 10);
    intr = 1'b0; rti_retire = 1'b1; step();
    rti_retire = 1'b0; step();

    // Second edge during DRAIN, serviced only after RTI
    intr = 1'b1; step(); step();
    intr = 1'b0; step();
    intr = 1'b1; step();
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin step(); if (int_ack) found = 1; end
    chk("t4_first_ack", 32'(found), 32'd1);
    restores = 0;
    repeat (19) begin step(); restores += int'(flags_restore); end
    rti_retire = 1'b1; flags_in = 4'b0101; step();
    rti_retire = 1'b0;
    restores += int'(flags_restore);
    chk("t4_restore_pulse", 32'(flags_restore), 32'd1);
    chk("t4_restored_flags", 32'(flags_saved), 32'b1010);
    chk("t4_idle_at_restore", 32'(busy), 32'd0);
    step();
    chk("t4_second_drain", 32'(freeze_fetch), 32'd1);
    acks = 0;
    repeat (40) begin step(); acks += int'(int_ack); restores += int'(flags_restore); end
    chk("t4_second_ack_only", acks, 1);
    chk("t4_restore_count", restores, 1);
    chk("t4_second_saved", 32'(flags_saved), 32'b0101);

    // Level held high: one sequence only
    rti_retire = 1'b1; step();
    rti_retire = 1'b0; intr = 1'b0; step();
    intr = 1'b1; acks = 0;
    repeat (60) begin step(); acks += int'(int_ack); end
    chk("t5_held_acks", acks, 1);
    rti_retire = 1'b1; step();
    rti_retire = 1'b0;
    repeat (20) begin step(); acks += int'(int_ack); end
    chk("t5_no_retrigger", acks, 1);
    chk("t5_idle", 32'(busy), 32'd0);

    // RTI outside an ISR
    rti_retire = 1'b1; step();
    chk("t6_no_restore", 32'(flags_restore), 32'd0);
    chk("t6_idle", 32'(busy), 32'd0);
    rti_retire = 1'b0; step();
    chk("t6_no_restore_late", 32'(flags_restore), 32'd0);

    // Randomized traffic checked every cycle against the model
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) intr = ~intr;
      stall_in       = ($urandom_range(0, 3) == 0);
      branch_pending = ($urandom_range(0, 6) == 0);
      rti_retire     = ($urandom_range(0, 19) == 0);
      flags_in       = 4'($urandom_range(0, 15));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
